peribus_timer: RTL and testbench

- Memory-mapped timer/counter peripheral; the responder end of the peribus that the CPU's data memory drives.
- The CPU performs register reads and writes over the bus.
- The block counts prescaled clock ticks, compares the count against a programmable period, and raises a level interrupt.
- It is the source feeding the CPU's interrupt controller.

---
 rtl/peribus_pkg.sv | 30 +++
 rtl/peribus_timer_if.sv | 31 +++
 rtl/tick_prescaler.sv | 35 +++
 rtl/peribus_timer.sv | 175 +++++++++++++++++
 tb/tb_peribus_timer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/peribus_pkg.sv
// Shared register map, bit positions and the CTRL layout for the peribus timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package peribus_pkg;

   localparam int REG_CTRL    = 0;
   localparam int REG_COUNT   = 1;
   localparam int REG_PERIOD  = 2;
   localparam int REG_STATUS  = 3;
   localparam int REG_CAPTURE = 4;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_IE     = 2;
   localparam int CTRL_PS_LSB = 3;
   localparam int CTRL_PS_W   = 3;

   localparam int ST_MATCH    = 0;
   localparam int ST_OVERRUN  = 1;
   localparam int ST_CAPT     = 2;

   // Field order mirrors the register bits so the struct reads back as-is.
   typedef struct packed {
      logic [CTRL_PS_W-1:0] ps;
      logic                 ie;
      logic                 reload;
      logic                 en;
   } ctrl_t;

endpackage

// File: rtl/peribus_timer_if.sv
// Peribus register access port: CPU data-memory side drives, peripheral responds.
// Latency: rdata is registered, valid the cycle after rd_en.
// Backpressure: none; strobes are single-cycle and always accepted.
interface peribus_timer_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) ();

   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  wdata;
   logic              wr_en;
   logic              rd_en;
   logic [WIDTH-1:0]  rdata;

   modport master (
      output addr,
      output wdata,
      output wr_en,
      output rd_en,
      input  rdata
   );

   modport slave (
      input  addr,
      input  wdata,
      input  wr_en,
      input  rd_en,
      output rdata
   );

endinterface

// File: rtl/tick_prescaler.sv
// Power-of-two clock divider: one-cycle tick every 2^ps clocks while enabled.
// Latency: first tick on the 2^ps-th cycle after clear/enable.
// Backpressure: none; clear restarts the phase immediately.
module tick_prescaler #(
   parameter int PRESCALE_MAX = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic [2:0] ps,
   output logic       tick
);

   logic [PRESCALE_MAX-1:0] pcnt;
   logic [PRESCALE_MAX-1:0] mask;

   always_comb begin
      mask = PRESCALE_MAX'((32'd1 << ps) - 32'd1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt <= '0;
      end else if (clear || !enable) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PRESCALE_MAX'(1);
      end
   end

   // All-ones in the low ps bits marks the last clock of each 2^ps window.
   assign tick = enable && ((pcnt & mask) == mask);

endmodule

// File: rtl/peribus_timer.sv
// Peribus timer: prescaled counter with period match and level irq; capture unit under PERIBUS_TIMER_CAPTURE_EN.
// Latency: reads return registered data one cycle after rd_en; writes land at the edge ending wr_en.
// Backpressure: none; every bus strobe is accepted in its own cycle.
module peribus_timer #(
   parameter int WIDTH        = 16,
   parameter int ADDR_W       = 3,
   parameter int PRESCALE_MAX = 7
) (
   input  logic           clk,
   input  logic           reset,
   peribus_timer_if.slave bus,
   output logic           irq,
   input  logic           capture_in
);

   import peribus_pkg::*;

   localparam int CTRL_W = $bits(ctrl_t);

   ctrl_t            ctrl;
   ctrl_t            ctrl_nxt;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] rd_word;
   logic             match;
   logic             match_nxt;
   logic             overrun;
   logic             overrun_nxt;
   logic             capt;
   logic             capt_nxt;

   logic             wr_ctrl;
   logic             wr_count;
   logic             wr_period;
   logic             wr_status;
   logic             tick;
   logic             stop_wr;
   logic             step;
   logic             hit;

   assign wr_ctrl   = bus.wr_en && (bus.addr == ADDR_W'(REG_CTRL));
   assign wr_count  = bus.wr_en && (bus.addr == ADDR_W'(REG_COUNT));
   assign wr_period = bus.wr_en && (bus.addr == ADDR_W'(REG_PERIOD));
   assign wr_status = bus.wr_en && (bus.addr == ADDR_W'(REG_STATUS));

   tick_prescaler #(
      .PRESCALE_MAX (PRESCALE_MAX)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (wr_ctrl | wr_count),
      .enable (ctrl.en),
      .ps     (ctrl.ps),
      .tick   (tick)
   );

   // A COUNT write, or a CTRL write that turns the timer off, owns this cycle's count update.
   assign stop_wr = wr_ctrl && !bus.wdata[CTRL_EN];
   assign step    = tick && !wr_count && !stop_wr;
   assign hit     = step && (count == period);

   always_comb begin
      ctrl_nxt = ctrl;
      if (wr_ctrl) begin
         ctrl_nxt.en     = bus.wdata[CTRL_EN];
         ctrl_nxt.reload = bus.wdata[CTRL_RELOAD];
         ctrl_nxt.ie     = bus.wdata[CTRL_IE];
         ctrl_nxt.ps     = bus.wdata[CTRL_PS_LSB +: CTRL_PS_W];
      end else if (hit && !ctrl.reload) begin
         ctrl_nxt.en = 1'b0;
      end

      count_nxt = count;
      if (wr_count) begin
         count_nxt = bus.wdata;
      end else if (hit) begin
         count_nxt = '0;
      end else if (step) begin
         count_nxt = count + WIDTH'(1);
      end

      // Set beats write-1-to-clear when both land in the same cycle.
      match_nxt   = hit | (match & ~(wr_status & bus.wdata[ST_MATCH]));
      overrun_nxt = (hit & match) | (overrun & ~(wr_status & bus.wdata[ST_OVERRUN]));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl    <= '0;
         count   <= '0;
         period  <= '1;
         match   <= 1'b0;
         overrun <= 1'b0;
         irq     <= 1'b0;
      end else begin
         ctrl    <= ctrl_nxt;
         count   <= count_nxt;
         match   <= match_nxt;
         overrun <= overrun_nxt;
         irq     <= (match_nxt | capt_nxt) & ctrl_nxt.ie;
         if (wr_period) begin
            period <= bus.wdata;
         end
      end
   end

`ifdef PERIBUS_TIMER_CAPTURE_EN
   logic cap_meta;
   logic cap_sync;
   logic cap_prev;
   logic cap_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_meta <= 1'b0;
         cap_sync <= 1'b0;
         cap_prev <= 1'b0;
      end else begin
         cap_meta <= capture_in;
         cap_sync <= cap_meta;
         cap_prev <= cap_sync;
      end
   end

   assign cap_edge = cap_sync & ~cap_prev;
   assign capt_nxt = cap_edge | (capt & ~(wr_status & bus.wdata[ST_CAPT]));

   // Snapshot is the count as it stood before this cycle's update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         capture <= '0;
         capt    <= 1'b0;
      end else begin
         capt <= capt_nxt;
         if (cap_edge) begin
            capture <= count;
         end
      end
   end
`else
   logic unused_capture_in;

   assign unused_capture_in = capture_in;
   assign capture           = '0;
   assign capt              = 1'b0;
   assign capt_nxt          = 1'b0;
`endif

   always_comb begin
      rd_word = '0;
      case (bus.addr)
         ADDR_W'(REG_CTRL):    rd_word[CTRL_W-1:0] = ctrl;
         ADDR_W'(REG_COUNT):   rd_word = count;
         ADDR_W'(REG_PERIOD):  rd_word = period;
         ADDR_W'(REG_STATUS): begin
            rd_word[ST_MATCH]   = match;
            rd_word[ST_OVERRUN] = overrun;
            rd_word[ST_CAPT]    = capt;
         end
         ADDR_W'(REG_CAPTURE): rd_word = capture;
         default:              rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.rdata <= '0;
      end else if (bus.rd_en) begin
         bus.rdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_peribus_timer.sv
// Self-checking bench for peribus_timer: directed scenarios plus randomized bus traffic against a register-level model.
// Capture checks follow PERIBUS_TIMER_CAPTURE_EN.
module tb_peribus_timer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic irq;
   logic capture_in;

   int total = 0;
   int bad   = 0;

   peribus_timer_if #(.WIDTH(16), .ADDR_W(3)) bus ();

   peribus_timer #(
      .WIDTH        (16),
      .ADDR_W       (3),
      .PRESCALE_MAX (7)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .irq        (irq),
      .capture_in (capture_in)
   );

   always #5 clk = ~clk;

   // Architectural state of the timer as the register map describes it.
   typedef struct packed {
      bit        en;
      bit        reload;
      bit        ie;
      bit [2:0]  ps;
      bit [15:0] count;
      bit [15:0] period;
      bit [15:0] capture;
      bit [15:0] rdata;
      bit        match;
      bit        ovr;
      bit        capt;
      bit        irq;
      int        age;
      bit        s1;
      bit        s2;
      bit        prev;
   } model_t;

   model_t ms;

   function automatic model_t model_reset();
      model_t n;
      n = '0;
      n.period = 16'hFFFF;
      return n;
   endfunction

   function automatic model_t model_next(input model_t s, input bit wr, input bit rd,
                                         input bit [2:0] a, input bit [15:0] d, input bit cin);
      model_t n;
      bit wc, wn, ws, tk, hit;
      n  = s;
      wc = wr && (a == 3'd0);
      wn = wr && (a == 3'd1);
      ws = wr && (a == 3'd3);
      if (rd) begin
         case (a)
            3'd0:    n.rdata = {10'd0, s.ps, s.ie, s.reload, s.en};
            3'd1:    n.rdata = s.count;
            3'd2:    n.rdata = s.period;
            3'd3:    n.rdata = {13'd0, s.capt, s.ovr, s.match};
            3'd4:    n.rdata = s.capture;
            default: n.rdata = 16'd0;
         endcase
      end
      // age = clocks since the timebase last restarted; a tick closes each 2^ps window
      tk  = s.en && (((s.age + 1) % (1 << s.ps)) == 0) && !wn && !(wc && !d[0]);
      hit = tk && (s.count == s.period);
      n.age = (!s.en || wc || wn) ? 0 : s.age + 1;
      if (wn)       n.count = d;
      else if (hit) n.count = 16'd0;
      else if (tk)  n.count = s.count + 16'd1;
      if (wr && (a == 3'd2)) n.period = d;
      if (wc) begin
         n.en     = d[0];
         n.reload = d[1];
         n.ie     = d[2];
         n.ps     = d[5:3];
      end else if (hit && !s.reload) begin
         n.en = 1'b0;
      end
      n.match = hit || (s.match && !(ws && d[0]));
      n.ovr   = (hit && s.match) || (s.ovr && !(ws && d[1]));
`ifdef PERIBUS_TIMER_CAPTURE_EN
      if (s.s2 && !s.prev) begin
         n.capt    = 1'b1;
         n.capture = s.count;
      end else begin
         n.capt = s.capt && !(ws && d[2]);
      end
`endif
      n.s1   = cin;
      n.s2   = s.s1;
      n.prev = s.s2;
      n.irq  = (n.match || n.capt) && n.ie;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) ms <= model_reset();
      else       ms <= model_next(ms, bus.wr_en, bus.rd_en, bus.addr, bus.wdata, capture_in);
   end

   task automatic bus_write(input int a, input int d);
      bus.addr  = 3'(a);
      bus.wdata = 16'(d);
      bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic bus_read(input int a, output logic [15:0] d);
      bus.addr  = 3'(a);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      d = bus.rdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic quiesce();
      bus_write(0, 0);
      bus_write(3, 7);
      bus_write(1, 0);
   endtask

   task automatic test_reset();
      logic [15:0] v;
      logic [15:0] exp_tab [8];
      exp_tab = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
      total++;
      if (bus.rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0000", bus.rdata); end
      for (int a = 0; a < 8; a++) begin
         bus_read(a, v);
         total++;
         if (v !== exp_tab[a]) begin
            bad++;
            $display("FAIL reset_reg%0d: got %h expected %h", a, v, exp_tab[a]);
         end
      end
   endtask

   task automatic test_reload();
      logic [15:0] v;
      logic [15:0] seq [5];
      seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
      quiesce();
      bus_write(2, 3);
      bus_write(0, 7);
      for (int i = 0; i < 5; i++) begin
         bus_read(1, v);
         total++;
         if (v !== seq[i]) begin bad++; $display("FAIL reload_count%0d: got %h expected %h", i, v, seq[i]); end
      end
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL reload_irq_high: got %b expected 1", irq); end
      bus_read(3, v);
      total++;
      if (v !== 16'h0001) begin bad++; $display("FAIL reload_status: got %h expected 0001", v); end
      bus_write(3, 1);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL reload_irq_clear: got %b expected 0", irq); end
      bus_write(0, 0);
   endtask

   task automatic test_oneshot();
      logic [15:0] v;
      quiesce();
      bus_write(2, 2);
      bus_write(0, 1);
      idle(6);
      bus_read(0, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_ctrl: got %h expected 0000", v); end
      bus_read(1, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_count: got %h expected 0000", v); end
      bus_read(3, v);
      total++;
      if (v !== 16'h0001) begin bad++; $display("FAIL oneshot_status: got %h expected 0001", v); end
      bus_write(3, 1);
      idle(6);
      bus_read(3, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_no_rematch: got %h expected 0000", v); end
      bus_read(1, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL oneshot_count_held: got %h expected 0000", v); end
   endtask

   task automatic test_prescale();
      logic [15:0] v;
      logic [15:0] e;
      quiesce();
      bus_write(2, 1);
      bus_write(0, 16'h13);
      for (int i = 0; i < 7; i++) begin
         e = (i < 4) ? 16'd0 : 16'd1;
         bus_read(1, v);
         total++;
         if (v !== e) begin bad++; $display("FAIL prescale_count%0d: got %h expected %h", i, v, e); end
      end
      bus_read(3, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL prescale_early_match: got %h expected 0000", v); end
      bus_read(3, v);
      total++;
      if (v !== 16'h0001) begin bad++; $display("FAIL prescale_match8: got %h expected 0001", v); end
      bus_write(0, 0);
   endtask

   task automatic test_overrun();
      logic [15:0] v;
      quiesce();
      bus_write(2, 3);
      bus_write(0, 3);
      idle(4);
      bus_read(3, v);
      total++;
      if (v !== 16'h0001) begin bad++; $display("FAIL ovr_first_match: got %h expected 0001", v); end
      bus_write(3, 1);
      idle(1);
      bus_write(3, 1);
      bus_read(3, v);
      total++;
      if (v !== 16'h0001) begin bad++; $display("FAIL ovr_clear_vs_set: got %h expected 0001", v); end
      idle(3);
      bus_read(3, v);
      total++;
      if (v !== 16'h0003) begin bad++; $display("FAIL ovr_two_matches: got %h expected 0003", v); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL ovr_irq_masked: got %b expected 0", irq); end
      quiesce();
      bus_write(2, 0);
      bus_write(0, 3);
      idle(3);
      bus_read(3, v);
      total++;
      if (v !== 16'h0003) begin bad++; $display("FAIL period0_status: got %h expected 0003", v); end
      bus_read(1, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL period0_count: got %h expected 0000", v); end
      bus_write(0, 0);
   endtask

   task automatic test_count_write();
      logic [15:0] v;
      logic [15:0] wrap_seq [4];
      wrap_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      quiesce();
      bus_write(2, 16'h0100);
      bus_write(0, 3);
      idle(2);
      bus_write(1, 16'h0010);
      bus_read(1, v);
      total++;
      if (v !== 16'h0010) begin bad++; $display("FAIL count_write_wins: got %h expected 0010", v); end
      bus_read(1, v);
      total++;
      if (v !== 16'h0011) begin bad++; $display("FAIL count_after_write: got %h expected 0011", v); end
      quiesce();
      bus_write(2, 1);
      bus_write(1, 16'hFFFE);
      bus_write(0, 3);
      for (int i = 0; i < 4; i++) begin
         bus_read(1, v);
         total++;
         if (v !== wrap_seq[i]) begin bad++; $display("FAIL wrap_count%0d: got %h expected %h", i, v, wrap_seq[i]); end
      end
      bus_read(3, v);
      total++;
      if (v !== 16'h0001) begin bad++; $display("FAIL wrap_match: got %h expected 0001", v); end
      bus_write(0, 0);
   endtask

   task automatic test_capture();
      logic [15:0] v;
      quiesce();
      bus_write(1, 5);
      bus_write(0, 4);
      capture_in = 1'b1;
      idle(4);
      capture_in = 1'b0;
      idle(3);
`ifdef PERIBUS_TIMER_CAPTURE_EN
      bus_read(4, v);
      total++;
      if (v !== 16'h0005) begin bad++; $display("FAIL capture_value: got %h expected 0005", v); end
      bus_read(3, v);
      total++;
      if (v !== 16'h0004) begin bad++; $display("FAIL capture_status: got %h expected 0004", v); end
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL capture_irq: got %b expected 1", irq); end
      bus_write(3, 4);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL capture_irq_clear: got %b expected 0", irq); end
`else
      bus_read(4, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL capture_off_value: got %h expected 0000", v); end
      bus_read(3, v);
      total++;
      if (v !== 16'h0000) begin bad++; $display("FAIL capture_off_status: got %h expected 0000", v); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL capture_off_irq: got %b expected 0", irq); end
`endif
      bus_write(0, 0);
   endtask

   task automatic test_reset_mid();
      logic [15:0] v;
      logic [15:0] exp_tab [4];
      exp_tab = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
      quiesce();
      bus_write(2, 1);
      bus_write(0, 7);
      idle(3);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL midreset_irq_before: got %b expected 1", irq); end
      reset = 1'b1;
      #1;
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq_async: got %b expected 0", irq); end
      total++;
      if (bus.rdata !== 16'h0) begin bad++; $display("FAIL midreset_rdata: got %h expected 0000", bus.rdata); end
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus_read(a, v);
         total++;
         if (v !== exp_tab[a]) begin bad++; $display("FAIL midreset_reg%0d: got %h expected %h", a, v, exp_tab[a]); end
      end
   endtask

   task automatic test_random();
      bit [2:0]  a;
      bit [15:0] d;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         a = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         d = 16'($urandom);
         case (a)
            3'd0: begin
               d[5:3] = 3'($urandom_range(0, 2));
               if ($urandom_range(0, 4) != 0) d[0] = 1'b1;
            end
            3'd1: d = ($urandom_range(0, 7) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                  : 16'($urandom_range(0, 15));
            3'd2: d = 16'($urandom_range(0, 10));
            3'd3: d = 16'($urandom_range(0, 7));
            default: ;
         endcase
         bus.addr  = a;
         bus.wdata = d;
         bus.wr_en = ($urandom_range(0, 99) < 25);
         bus.rd_en = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) capture_in = ~capture_in;
         @(negedge clk);
         total++;
         if (bus.rdata !== ms.rdata) begin
            bad++;
            $display("FAIL rand_rdata cyc %0d: got %h expected %h", cyc, bus.rdata, ms.rdata);
         end
         total++;
         if (irq !== ms.irq) begin
            bad++;
            $display("FAIL rand_irq cyc %0d: got %b expected %b", cyc, irq, ms.irq);
         end
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   initial begin
      bus.addr   = '0;
      bus.wdata  = '0;
      bus.wr_en  = 1'b0;
      bus.rd_en  = 1'b0;
      capture_in = 1'b0;
      test_reset();
      test_reload();
      test_oneshot();
      test_prescale();
      test_overrun();
      test_count_write();
      test_capture();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
